// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and sizing for the BCD-to-binary converter
package bcd_pkg;
  typedef enum logic [1:0] {OCIOSO, CONV, FEITO} estado_t;
  localparam int N_DIG = 4;
  localparam int DIGITO_MAX = 9;
  localparam int ACC_W = 14;
endpackage

// File: rtl/passo_bcd.sv
// passo_bcd: one Horner step acc*10+digit using shifts, plus digit range flag
module passo_bcd
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digito,
  output logic [ACC_W-1:0] prox,
  output logic             invalido
);
  // acc*10 = acc*8 + acc*2; only digits 0..9 are legal BCD
  always_comb begin
    prox = {acc[ACC_W-4:0], 3'b000} + {acc[ACC_W-2:0], 1'b0} + {{(ACC_W-4){1'b0}}, digito};
    invalido = digito > 4'(DIGITO_MAX);
  end
endmodule

// File: rtl/bcd_para_bin.sv
// bcd_para_bin: serial 4-digit BCD to binary converter, one digit per clock
module bcd_para_bin
  import bcd_pkg::*;
#(
  parameter int N_DIG = bcd_pkg::N_DIG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [3:0]  entrada1,
  input  logic [3:0]  entrada2,
  input  logic [3:0]  entrada3,
  input  logic [3:0]  entrada4,
  output logic [31:0] valor,
  output logic        pronto,
  output logic        ocupado,
  output logic        erro
);
  estado_t estado, prox_estado;
  logic [N_DIG-1:0][3:0] dig;
  logic [ACC_W-1:0] acc, prox_acc;
  logic [1:0] idx;
  logic err, inv, aceita, ultimo;
  passo_bcd u_passo (.acc(acc), .digito(dig[N_DIG-1]), .prox(prox_acc), .invalido(inv));
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) estado <= OCIOSO;
    else estado <= prox_estado;
  // next state and status outputs; a request in FEITO restarts without an idle cycle
  always_comb begin
    aceita = inicio && (estado != CONV);
    ultimo = (estado == CONV) && (idx == 2'(N_DIG-1));
    prox_estado = aceita ? CONV : ultimo ? FEITO : (estado == FEITO) ? OCIOSO : estado;
    pronto = estado == FEITO;
    ocupado = estado == CONV;
  end
  // datapath: latch digits most significant first, shift one out per step, publish on FEITO entry
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      dig <= '0;
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
      valor <= '0;
      erro <= 1'b0;
    end else if (aceita) begin
      dig <= {entrada4, entrada3, entrada2, entrada1};
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
    end else if (estado == CONV) begin
      dig <= {dig[N_DIG-2:0], 4'h0};
      acc <= prox_acc;
      idx <= idx + 2'd1;
      err <= err | inv;
      if (ultimo) begin
        valor <= (err | inv) ? 32'd0 : 32'(prox_acc);
        erro <= err | inv;
      end
    end
endmodule

// File: tb/tb_bcd_para_bin.sv
// tb_bcd_para_bin: randomized and directed checks against an arithmetic reference model
module tb_bcd_para_bin;
  logic clock = 1'b0, reset = 1'b1, inicio = 1'b0;
  logic [3:0] entrada1 = '0, entrada2 = '0, entrada3 = '0, entrada4 = '0;
  logic [31:0] valor;
  logic pronto, ocupado, erro;
  int errors = 0, checks = 0;
  bcd_para_bin dut (.clock(clock), .reset(reset), .inicio(inicio), .entrada1(entrada1),
    .entrada2(entrada2), .entrada3(entrada3), .entrada4(entrada4), .valor(valor),
    .pronto(pronto), .ocupado(ocupado), .erro(erro));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void modelo(input int d4, d3, d2, d1, output int v, output bit e);
    e = d4 > 9 || d3 > 9 || d2 > 9 || d1 > 9;
    v = e ? 0 : d4 * 1000 + d3 * 100 + d2 * 10 + d1;
  endfunction
  // one conversion starting at a negedge; leaves the bench at the FEITO negedge with inicio high
  task automatic serie(input int d4, d3, d2, d1, input bit junk, input bit full);
    int v;
    bit e;
    modelo(d4, d3, d2, d1, v, e);
    {entrada4, entrada3, entrada2, entrada1} = {4'(d4), 4'(d3), 4'(d2), 4'(d1)};
    inicio = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (full) begin
        check("ocupado_conv", 32'(ocupado), 32'd1);
        check("pronto_conv", 32'(pronto), 32'd0);
      end
      if (junk) {entrada4, entrada3, entrada2, entrada1} = 16'($urandom);
    end
    @(negedge clock);
    if (full) begin
      check("pronto_feito", 32'(pronto), 32'd1);
      check("ocupado_feito", 32'(ocupado), 32'd0);
      check("erro", 32'(erro), 32'(e));
    end
    check("valor", valor, 32'(v));
  endtask
  task automatic conv(input int d4, d3, d2, d1, input bit junk);
    serie(d4, d3, d2, d1, junk, 1'b1);
    inicio = 1'b0;
    @(negedge clock);
    check("pronto_idle", 32'(pronto), 32'd0);
    check("ocupado_idle", 32'(ocupado), 32'd0);
  endtask
  initial begin
    inicio = 1'b1;
    #1;
    check("rst_valor", valor, 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    repeat (2) @(negedge clock);
    check("rst_ignora_inicio", 32'(ocupado), 32'd0);
    inicio = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    conv(1, 2, 3, 4, 1'b0);
    conv(9, 9, 9, 9, 1'b0);
    conv(0, 0, 0, 0, 1'b0);
    conv(0, 10, 0, 0, 1'b0);
    conv(0, 0, 4, 2, 1'b0);
    conv(15, 15, 15, 15, 1'b0);
    conv(0, 0, 0, 9, 1'b0);
    for (int k = 0; k < 6; k++)
      serie($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), 1'b1, 1'b1);
    inicio = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 40; k++)
      conv($urandom_range(0, 15), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 11), 1'b1);
    {entrada4, entrada3, entrada2, entrada1} = 16'h5678;
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    @(negedge clock);
    check("ocupado_antes_rst", 32'(ocupado), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_meio_valor", valor, 32'd0);
    check("rst_meio_pronto", 32'(pronto), 32'd0);
    check("rst_meio_ocupado", 32'(ocupado), 32'd0);
    check("rst_meio_erro", 32'(erro), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      check("sem_pronto_pos_rst", 32'(pronto), 32'd0);
    end
    conv(8, 0, 7, 1, 1'b0);
    for (int v = 0; v < 10000; v++)
      serie(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10, 1'b0, 1'b0);
    inicio = 1'b0;
    @(negedge clock);
    check("fim_pronto", 32'(pronto), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
